// File: rtl/ram_fifo_ctrl.sv
// Circular FIFO controller over a dual-port RAM: owns the pointers, occupancy,
// status flags and the read-latency valid pipeline so clients never see RAM addresses.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int RD_LATENCY   = 0,
  parameter int AFULL_THRESH = 4064
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   used_words,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_wraddress,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic                  flush_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  cap_s;
  logic [RD_LATENCY:0]   vld_next_s;
  logic [ADDR_WIDTH:0]   used_next_s;

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   used_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  afull_r;
  logic                  ovf_r;
  logic                  unf_r;
  logic [RD_LATENCY:0]   vld_r;
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Request acceptance and next-state occupancy; a flush blocks both ports.
  always_comb begin
    flush_s  = reset | clear;
    wr_acc_s = wr_req & ~full_r & ~flush_s;
    rd_acc_s = rd_req & ~empty_r & ~flush_s;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   used_next_s = used_r + CNT_ONE;
      2'b01:   used_next_s = used_r - CNT_ONE;
      default: used_next_s = used_r;
    endcase
  end

  // Capture strobe is the valid bit one stage before it reaches rd_valid.
  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign cap_s      = rd_acc_s;
      assign vld_next_s = rd_acc_s;
    end else begin : g_latn
      assign cap_s      = vld_r[RD_LATENCY-1];
      assign vld_next_s = {vld_r[RD_LATENCY-1:0], rd_acc_s};
    end
  endgenerate

  // Pointers, occupancy, flags and reject pulses.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      used_r   <= {(ADDR_WIDTH+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_acc_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      used_r  <= used_next_s;
      full_r  <= (used_next_s == DEPTH_C);
      empty_r <= (used_next_s == {(ADDR_WIDTH+1){1'b0}});
      afull_r <= (used_next_s >= AFULL_C);
      ovf_r   <= wr_req & full_r;
      unf_r   <= rd_req & empty_r;
    end
  end

  // Read-valid pipeline and read-data capture; a flush discards reads in flight.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      vld_r     <= {(RD_LATENCY+1){1'b0}};
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      vld_r <= vld_next_s;
      if (cap_s) rd_data_r <= ram_q;
    end
  end

  assign ram_wren      = wr_acc_s;
  assign ram_wraddress = wr_ptr_r;
  assign ram_data      = wr_data;
  assign ram_rdaddress = rd_ptr_r;
  assign rd_data       = rd_data_r;
  assign rd_valid      = vld_r[RD_LATENCY];
  assign full          = full_r;
  assign empty         = empty_r;
  assign almost_full   = afull_r;
  assign used_words    = used_r;
  assign overflow      = ovf_r;
  assign underflow     = unf_r;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: a queue-based FIFO model drives expectations
// for a zero-latency instance, plus a fixed-timing check of a two-cycle-latency instance.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 4096;
  localparam int AFULL = 4064;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, clear0, wr0, rd0;
  logic [15:0] wd0, rdd0, ramd0, ramq0;
  logic        rv0, full0, empty0, af0, ovf0, unf0, ramwe0;
  logic [12:0] used0;
  logic [11:0] ramwa0, ramra0;

  logic        clear2, wr2, rd2;
  logic [15:0] wd2, rdd2, ramd2, ramq2;
  logic        rv2, full2, empty2, af2, ovf2, unf2, ramwe2;
  logic [12:0] used2;
  logic [11:0] ramwa2, ramra2;

  ram_fifo_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .RD_LATENCY(0), .AFULL_THRESH(4064)) dut0 (
    .clock(clock), .reset(reset), .clear(clear0), .wr_req(wr0), .wr_data(wd0), .rd_req(rd0),
    .rd_data(rdd0), .rd_valid(rv0), .full(full0), .empty(empty0), .almost_full(af0),
    .used_words(used0), .overflow(ovf0), .underflow(unf0), .ram_data(ramd0),
    .ram_wraddress(ramwa0), .ram_rdaddress(ramra0), .ram_wren(ramwe0), .ram_q(ramq0));

  ram_fifo_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .RD_LATENCY(2), .AFULL_THRESH(4064)) dut2 (
    .clock(clock), .reset(reset), .clear(clear2), .wr_req(wr2), .wr_data(wd2), .rd_req(rd2),
    .rd_data(rdd2), .rd_valid(rv2), .full(full2), .empty(empty2), .almost_full(af2),
    .used_words(used2), .overflow(ovf2), .underflow(unf2), .ram_data(ramd2),
    .ram_wraddress(ramwa2), .ram_rdaddress(ramra2), .ram_wren(ramwe2), .ram_q(ramq2));

  // Unregistered RAM for the zero-latency instance.
  logic [15:0] mem0 [0:DEPTH-1];
  always @(posedge clock) if (ramwe0) mem0[ramwa0] <= ramd0;
  assign ramq0 = mem0[ramra0];

  // Registered-address, registered-output RAM: two clocks of read latency.
  logic [15:0] mem2 [0:DEPTH-1];
  logic [11:0] ra2_q;
  logic [15:0] q2_q;
  always @(posedge clock) begin
    if (ramwe2) mem2[ramwa2] <= ramd2;
    ra2_q <= ramra2;
    q2_q  <= mem2[ra2_q];
  end
  assign ramq2 = q2_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mq[$];
  int          wr_total = 0;
  int          rd_total = 0;
  logic        exp_valid, exp_ovf, exp_unf, exp_wren;
  logic [15:0] exp_data;
  logic [11:0] exp_wa, exp_ra;
  logic        obs_wren;
  logic [11:0] obs_wa, obs_ra;

  function automatic logic [59:0] act0();
    return {rdd0, used0, full0, empty0, af0, rv0, ovf0, unf0, obs_wren, obs_wa, obs_ra};
  endfunction

  function automatic logic [59:0] exp_status();
    int n;
    n = mq.size();
    return {exp_data, 13'(n), (n == DEPTH), (n == 0), (n >= AFULL),
            exp_valid, exp_ovf, exp_unf, exp_wren, exp_wa, exp_ra};
  endfunction

  // One clock on dut0, updating the FIFO model from the acceptance rules.
  task automatic step(input logic wr, input logic [15:0] d, input logic rd,
                      input logic rst, input logic clr);
    logic wok, rok, fl;
    fl  = rst | clr;
    wok = wr && (mq.size() < DEPTH) && !fl;
    rok = rd && (mq.size() > 0) && !fl;
    exp_wren = wok;
    exp_wa   = 12'(wr_total % DEPTH);
    exp_ra   = 12'(rd_total % DEPTH);
    reset = rst; clear0 = clr; wr0 = wr; wd0 = d; rd0 = rd;
    @(negedge clock);
    obs_wren = ramwe0; obs_wa = ramwa0; obs_ra = ramra0;
    @(posedge clock);
    if (fl) begin
      mq.delete();
      wr_total = 0; rd_total = 0;
      exp_valid = 1'b0; exp_data = 16'h0000; exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      exp_valid = rok;
      exp_ovf   = wr && !wok;
      exp_unf   = rd && !rok;
      if (rok) begin exp_data = mq.pop_front(); rd_total++; end
      if (wok) begin mq.push_back(d); wr_total++; end
    end
    #1;
  endtask

  task automatic step2(input logic wr, input logic [15:0] d, input logic rd, input logic clr);
    wr2 = wr; wd2 = d; rd2 = rd; clear2 = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'($urandom), 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (act0() !== exp_status()) begin
      n_fail++; $display("FAIL reset: got %h, required %h", act0(), exp_status());
    end
    n_tests++;
    if ({rv2, empty2, full2, af2, used2, rdd2, ovf2, unf2} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_lat2: got v=%b e=%b u=%0d d=%h", rv2, empty2, used2, rdd2);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (act0() !== exp_status()) begin
      n_fail++; $display("FAIL reset_idle: got %h, required %h", act0(), exp_status());
    end
  endtask

  task automatic test_basic();
    logic [15:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (act0() !== exp_status()) begin
        n_fail++; $display("FAIL basic push %0d: got %h, required %h", i, act0(), exp_status());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (act0() !== exp_status() || rv0 !== 1'b1 || rdd0 !== vals[i]) begin
        n_fail++; $display("FAIL basic pop %0d: got %h, required %h (data %h)", i, act0(), exp_status(), vals[i]);
      end
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (act0() !== exp_status() || empty0 !== 1'b1) begin
      n_fail++; $display("FAIL basic empty: got %h, required %h", act0(), exp_status());
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (act0() !== exp_status()) begin
        n_fail++; $display("FAIL full push %0d: got %h, required %h", i, act0(), exp_status());
      end
    end
    step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (act0() !== exp_status() || ovf0 !== 1'b1 || obs_wren !== 1'b0) begin
      n_fail++; $display("FAIL overflow: got %h, required %h", act0(), exp_status());
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (act0() !== exp_status()) begin
      n_fail++; $display("FAIL overflow_once: got %h, required %h", act0(), exp_status());
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (act0() !== exp_status() || rdd0 !== 16'(i)) begin
        n_fail++; $display("FAIL full pop %0d: got %h, required %h", i, act0(), exp_status());
      end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (act0() !== exp_status() || unf0 !== 1'b1 || rv0 !== 1'b0) begin
      n_fail++; $display("FAIL underflow: got %h, required %h", act0(), exp_status());
    end
    step(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (act0() !== exp_status() || used0 !== 13'd1) begin
      n_fail++; $display("FAIL push_pop_empty: got %h, required %h", act0(), exp_status());
    end
    step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (act0() !== exp_status() || used0 !== 13'd1 || rdd0 !== 16'hABCD) begin
      n_fail++; $display("FAIL push_pop_one: got %h, required %h", act0(), exp_status());
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (act0() !== exp_status()) begin
      n_fail++; $display("FAIL underflow_drain: got %h, required %h", act0(), exp_status());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (act0() !== exp_status() || used0 !== 13'd10) begin
        n_fail++; $display("FAIL wrap %0d: got %h, required %h", i, act0(), exp_status());
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (act0() !== exp_status()) begin
        n_fail++; $display("FAIL wrap_drain %0d: got %h, required %h", i, act0(), exp_status());
      end
    end
  endtask

  task automatic test_random();
    logic wr, rd, clr;
    for (int i = 0; i < 2000; i++) begin
      wr  = ($urandom_range(0, 99) < 60);
      rd  = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 249) == 0);
      step(wr, 16'($urandom), rd, 1'b0, clr);
      n_tests++;
      if (act0() !== exp_status()) begin
        n_fail++; $display("FAIL random %0d: got %h, required %h", i, act0(), exp_status());
      end
    end
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (act0() !== exp_status() || used0 !== 13'd0 || rv0 !== 1'b0) begin
      n_fail++; $display("FAIL clear: got %h, required %h", act0(), exp_status());
    end
  endtask

  task automatic test_latency2();
    logic [15:0] v [4];
    logic        ev;
    logic [15:0] ed;
    for (int i = 0; i < 4; i++) begin
      v[i] = 16'($urandom);
      step2(1'b1, v[i], 1'b0, 1'b0);
    end
    n_tests++;
    if (used2 !== 13'd4) begin
      n_fail++; $display("FAIL lat2 fill: got %0d, required 4", used2);
    end
    // single pop: valid only in the third cycle after the pop cycle
    for (int k = 1; k <= 4; k++) begin
      step2(1'b0, 16'h0000, (k == 1), 1'b0);
      ev = (k == 3);
      ed = (k >= 3) ? v[0] : 16'h0000;
      n_tests++;
      if ({rv2, rdd2} !== {ev, ed}) begin
        n_fail++; $display("FAIL lat2 single k=%0d: got v=%b d=%h, required v=%b d=%h", k, rv2, rdd2, ev, ed);
      end
    end
    // back-to-back pops give back-to-back valids
    for (int k = 1; k <= 5; k++) begin
      step2(1'b0, 16'h0000, (k <= 2), 1'b0);
      ev = (k == 3) || (k == 4);
      ed = (k < 3) ? v[0] : ((k == 3) ? v[1] : v[2]);
      n_tests++;
      if ({rv2, rdd2} !== {ev, ed}) begin
        n_fail++; $display("FAIL lat2 b2b k=%0d: got v=%b d=%h, required v=%b d=%h", k, rv2, rdd2, ev, ed);
      end
    end
    // clear one cycle after a pop discards the read in flight
    for (int k = 1; k <= 4; k++) begin
      step2(1'b0, 16'h0000, (k == 1), (k == 2));
      n_tests++;
      if (rv2 !== 1'b0 || rdd2 !== ((k >= 2) ? 16'h0000 : v[2])) begin
        n_fail++; $display("FAIL lat2 clear k=%0d: got v=%b d=%h, required v=0", k, rv2, rdd2);
      end
      if (k >= 2) begin
        n_tests++;
        if ({empty2, used2} !== {1'b1, 13'd0}) begin
          n_fail++; $display("FAIL lat2 clear_state k=%0d: got e=%b u=%0d, required e=1 u=0", k, empty2, used2);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; wd0 = 16'h0000;
    clear2 = 1'b0; wr2 = 1'b0; rd2 = 1'b0; wd2 = 16'h0000;
    exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0; exp_wren = 1'b0;
    exp_data = 16'h0000; exp_wa = 12'h000; exp_ra = 12'h000;
    test_reset();
    test_latency2();
    test_basic();
    test_full();
    test_underflow();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Initiator/controller for the 16-bit x 4096-word dual-port Basic_RAM. It drives the RAM write port and read port, and uses the RAM as circular FIFO storage. Upstream logic pushes words with wr_req; downstream logic pops them with rd_req and receives registered read data with rd_valid. It owns the pointers, occupancy, flags and the read-latency pipeline, so client logic never touches RAM addresses.

Parameters:
DATA_WIDTH, 16, word width; must match the RAM data/q width.
ADDR_WIDTH, 12, RAM address width; depth = 2**ADDR_WIDTH = 4096.
RD_LATENCY, 0, internal RAM read latency in clocks (0 = unregistered q).
AFULL_THRESH, 4064, almost_full asserts when used_words >= this value.

Ports:
clock  in  1  single system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
clear  in  1  synchronous flush; same effect as reset on FIFO state.
wr_req  in  1  push request.
wr_data  in  DATA_WIDTH  push word.
rd_req  in  1  pop request.
rd_data  out  DATA_WIDTH  popped word (registered).
rd_valid  out  1  rd_data is valid this cycle (one-cycle pulse per pop).
full  out  1  used_words == 2**ADDR_WIDTH.
empty  out  1  used_words == 0.
almost_full  out  1  used_words >= AFULL_THRESH.
used_words  out  ADDR_WIDTH+1  current occupancy, 0..4096.
overflow  out  1  one-cycle pulse: wr_req rejected.
underflow  out  1  one-cycle pulse: rd_req rejected.
ram_data  out  DATA_WIDTH  to RAM data.
ram_wraddress  out  ADDR_WIDTH  to RAM wraddress.
ram_rdaddress  out  ADDR_WIDTH  to RAM rdaddress.
ram_wren  out  1  to RAM wren.
ram_q  in  DATA_WIDTH  from RAM q.

Behaviour:
- Reset or clear (synchronous, active-high): wr_ptr = 0, rd_ptr = 0, used_words = 0, empty = 1, full = 0, almost_full = 0, rd_valid = 0, rd_data = 0, overflow = 0, underflow = 0. The read-valid pipeline is cleared, so in-flight reads are discarded. reset takes priority over clear; both take priority over all requests.
- Write acceptance: wr_acc = wr_req & ~full.
  - ram_wren = wr_acc (combinational); ram_wraddress = wr_ptr; ram_data = wr_data.
  - wr_ptr increments mod 4096 on wr_acc.
  - wr_req & full: no RAM write; overflow pulses the next cycle. A write is rejected when full even if a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd_req & ~empty.
  - ram_rdaddress = rd_ptr (combinational); rd_ptr increments mod 4096 on rd_acc.
  - rd_req & empty: underflow pulses the next cycle. A read is rejected when empty even if a write is accepted in the same cycle, so no read-during-write to the same address ever occurs.
- Occupancy: used_words += wr_acc − rd_acc each clock. A simultaneous accepted read and write leaves the count unchanged. empty, full and almost_full are registered and derived from the next-state count, so they are correct in the cycle after the update.
- Read latency: rd_acc in cycle t captures ram_q at the edge ending cycle t+RD_LATENCY into rd_data. rd_valid is high for exactly cycle t+RD_LATENCY+1.
  - Implemented as a valid shift register of RD_LATENCY+1 stages.
  - rd_data holds its last value when rd_valid = 0.
  - Back-to-back pops give back-to-back rd_valid with full throughput (one word per clock).
- Ordering: strict FIFO, including across pointer wrap-around at 4095 -> 0.
- A write is visible to reads starting the cycle after it is accepted.

Test Plan:
- Reset: pulse reset with wr_req = rd_req = 1 -> empty = 1, used_words = 0, rd_valid = 0, ram_wren = 0 during reset; all outputs at their reset values.
- Basic order, RD_LATENCY = 0: push 0x1111, 0x2222, 0x3333, then pop 3 back-to-back -> rd_valid on 3 consecutive cycles, each one cycle after its pop, with data 0x1111, 0x2222, 0x3333; empty = 1 afterwards.
- Full and overflow: push 4096 words (0x0000..0x0FFF) -> full = 1 and used_words = 4096; almost_full = 1 from the 4064th push onward. One more push -> overflow pulses once and the RAM is not written. Pop all -> data 0x0000..0x0FFF in order.
- Underflow and simultaneous access: pop when empty -> underflow pulses, no rd_valid. Same-cycle push 0xABCD + pop on empty -> only the push is accepted, used_words = 1. Next cycle push + pop together -> used_words stays 1, rd_data = 0xABCD.
- Wrap-around: cycle 5000 words with occupancy held at 10 -> the pointers wrap, data matches the scoreboard, and used_words never deviates from 10.
- RD_LATENCY = 2 with a modelled registered RAM: pop at cycle t -> rd_valid at t+3. Assert clear at t+1 -> no rd_valid, empty = 1, used_words = 0.
